// File: rtl/fetch_responder.sv
// Memory-side fetch responder: byte-address requests in, in-order
// word responses out through a show-ahead FIFO; DMA load port fills the buffer.
module fetch_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  busy
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [PW:0] C_ONE = (PW+1)'(1);
    localparam logic [CW-1:0] CREDITS = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORDS = ADDR_WIDTH'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_err [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] req_off;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [ADDR_WIDTH-1:0] load_off;
    logic [ADDR_WIDTH-1:0] load_word;
    logic                  req_bad;
    logic                  load_bad;
    logic                  req_fire;

    logic                  s1_valid;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  s2_valid;
    logic                  s2_err;
    logic [DATA_WIDTH-1:0] s2_data;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic [CW-1:0]         outstanding;
    logic                  ready_en;
    logic                  push;
    logic                  pop;

    assign req_off = req_addr - BASE_ADDR;
    assign req_word = req_off >> 2;
    assign req_bad = (req_addr[1:0] != 2'b00) || (req_word >= WORDS);

    assign load_off = load_addr - BASE_ADDR;
    assign load_word = load_off >> 2;
    assign load_bad = (load_addr[1:0] != 2'b00) || (load_word >= WORDS);

    assign outstanding = CW'(s1_valid) + CW'(s2_valid) + CW'(count);
    assign req_ready = ready_en && (outstanding < CREDITS);
    assign req_fire = req_valid && req_ready;

    assign rsp_valid = (count != '0);
    assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_err = rsp_valid ? fifo_err[rd_ptr] : 1'b0;
    assign push = s2_valid;
    assign pop = rsp_valid && rsp_ready;
    assign busy = s1_valid | s2_valid | rsp_valid;

    // Read on the accept edge; nonblocking write makes collisions read-first.
    always_ff @(posedge clk) begin
        if (load_en && !load_bad)
            mem[load_word[IW-1:0]] <= load_data;
        if (req_fire && !req_bad)
            rd_data <= mem[req_word[IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= s2_data;
            fifo_err[wr_ptr] <= s2_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_err <= 1'b0;
            s2_valid <= 1'b0;
            s2_err <= 1'b0;
            s2_data <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= req_fire;
            s1_err <= req_bad;
            s2_valid <= s1_valid;
            s2_err <= s1_err;
            s2_data <= s1_err ? '0 : rd_data;
            if (push)
                wr_ptr <= wr_ptr + P_ONE;
            if (pop)
                rd_ptr <= rd_ptr + P_ONE;
            unique case ({push, pop})
                2'b10: count <= count + C_ONE;
                2'b01: count <= count - C_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed vector table, reset sequence,
// then random traffic against a queue-based reference model.
module tb_fetch_responder;

    localparam int DEPTH = 4;
    localparam int WORDS = 1024;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk;
    logic        rst;
    logic [31:0] req_addr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;

    fetch_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_DEPTH(WORDS),
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_addr(req_addr),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        le;
        logic [31:0] la;
        logic [31:0] ld;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    typedef struct {
        int          acc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[$];
    exp_t q[$];
    logic [31:0] mem_m [WORDS];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rv, input logic [31:0] ra, input logic rr,
        input logic le, input logic [31:0] la, input logic [31:0] ld,
        input logic e_rdy, input logic e_vld, input logic [31:0] e_data,
        input logic e_err, input logic e_busy);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rr = rr;
        v.le = le; v.la = la; v.ld = ld;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data;
        v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    function automatic logic [31:0] pick_addr();
        int s;
        logic [31:0] w;
        s = $urandom_range(0, 9);
        w = 32'($urandom_range(0, 15));
        if (s == 0) return BASE + 32'((WORDS - 1) * 4);
        if (s == 1) return BASE + (w << 2) + 32'($urandom_range(1, 3));
        if (s == 2) return BASE + 32'(WORDS * 4) + (w << 2);
        if (s == 3) return BASE + 32'hFFFF_FFFC;
        return BASE + (w << 2);
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] wd;
        wd = (a - BASE) / 4;
        return (a % 4 != 0) || (wd >= WORDS);
    endfunction

    function automatic int addr_word(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr = '0;
        rsp_ready = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " rsp_data"}, rsp_data, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        int          e_done;
        logic        m_rdy;
        logic        m_vis;
        exp_t        x;
        string       tag;

        rst = 1'b1;
        idle_inputs();
        #2;
        check_reset_vals("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            load_en = 1'b1;
            load_addr = BASE + 32'(i * 4);
            load_data = 32'hA0 + 32'(i);
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // single request, 2-cycle latency
        tbl.push_back(mk(1, 'h8, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hA2, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // back-to-back stream
        for (int k = 0; k < 11; k++)
            tbl.push_back(mk(k < 8, 32'(k * 4), 1, 0, 0, 0, 1,
                             k >= 2 && k < 10, 32'hA0 + 32'(k - 2),
                             0, k < 10));
        // backpressure fills credit, then drain
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1, 32'(k * 4), 0, 0, 0, 0, k < 3,
                             k >= 2, 'hA0, 0, 1));
        for (int k = 6; k < 10; k++)
            tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, k < 9,
                             32'hA0 + 32'(k - 5), 0, k < 9));
        // error requests keep order
        tbl.push_back(mk(1, 'h6, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 'h1000, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 'h4, 1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hA1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // read/load collision is read-first
        tbl.push_back(mk(1, 'hC, 1, 1, 'hC, 'h55, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hA3, 0, 1));
        tbl.push_back(mk(1, 'hC, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'h55, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            req_valid = tbl[i].rv;
            req_addr = tbl[i].ra;
            rsp_ready = tbl[i].rr;
            load_en = tbl[i].le;
            load_addr = tbl[i].la;
            load_data = tbl[i].ld;
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " req_ready"}, 32'(req_ready), 32'(tbl[i].e_rdy));
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(tbl[i].e_vld));
            chk({tag, " busy"}, 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_vld) begin
                chk({tag, " rsp_data"}, rsp_data, tbl[i].e_data);
                chk({tag, " rsp_err"}, 32'(rsp_err), 32'(tbl[i].e_err));
            end
        end
        idle_inputs();

        // reset with two requests still in the pipeline
        req_valid = 1'b1;
        req_addr = 32'h0;
        @(posedge clk);
        #1;
        req_addr = 32'h4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("postrst rsp_valid", 32'(rsp_valid), 32'd0);
            chk("postrst busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 17; i++) begin
            int w;
            w = (i == 16) ? WORDS - 1 : i;
            load_en = 1'b1;
            load_addr = BASE + 32'(w * 4);
            load_data = $urandom;
            mem_m[w] = load_data;
            @(posedge clk);
            #1;
        end
        idle_inputs();

        e_done = 0;
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr = pick_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            load_en = ($urandom_range(0, 3) == 0);
            load_addr = pick_addr();
            load_data = $urandom;
            #1;
            chk("push_into_full_fifo",
                32'(dut.s2_valid && dut.count == 3'(DEPTH)
                    && !(rsp_valid && rsp_ready)), 32'd0);
            @(posedge clk);
            m_rdy = (q.size() < DEPTH);
            m_vis = (q.size() > 0) && (e_done - q[0].acc >= 2);
            if (m_vis && rsp_ready)
                void'(q.pop_front());
            if (req_valid && m_rdy) begin
                x.acc = e_done + 1;
                x.err = addr_bad(req_addr);
                x.data = x.err ? 32'h0 : mem_m[addr_word(req_addr)];
                q.push_back(x);
            end
            if (load_en && !addr_bad(load_addr))
                mem_m[addr_word(load_addr)] = load_data;
            e_done++;
            #1;
            m_vis = (q.size() > 0) && (e_done - q[0].acc >= 2);
            chk("rnd req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            chk("rnd rsp_valid", 32'(rsp_valid), 32'(m_vis));
            chk("rnd busy", 32'(busy), 32'(q.size() != 0));
            if (m_vis) begin
                chk("rnd rsp_data", rsp_data, q[0].data);
                chk("rnd rsp_err", 32'(rsp_err), 32'(q[0].err));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
